// File: rtl/calc_pkg.sv
// Shared definitions for the calculator and its display stream: status
// encoding, command codes, the empty-position marker and active-low
// 7-segment glyphs ({g,f,e,d,c,b,a}, 0 = segment lit).
package calc_pkg;

  typedef enum logic [1:0] {
    ST_ERRO    = 2'd0,
    ST_PRONTA  = 2'd1,
    ST_OCUPADA = 2'd2
  } status_t;

  localparam logic [3:0] CMD_SOMA  = 4'b1010;
  localparam logic [3:0] CMD_SUBT  = 4'b1011;
  localparam logic [3:0] CMD_MULT  = 4'b1100;
  localparam logic [3:0] CMD_IGUAL = 4'b1110;
  localparam logic [3:0] CMD_BACKS = 4'b1111;

  localparam logic [3:0] POS_EMPTY = 4'hF;

  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_E     = 7'h06;
  localparam logic [6:0] SEG_R     = 7'h2F;
  localparam logic [6:0] SEG_O     = 7'h23;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

endpackage

// File: rtl/seg7_decoder.sv
// Combinational decimal-digit to active-low 7-segment decoder. Values
// 10..15, or an asserted blank flag, produce a dark digit.
module seg7_decoder
  import calc_pkg::*;
(
  input  logic [3:0] value,
  input  logic       blank,
  output logic [6:0] seg
);

  // Map the digit value to its glyph; anything non-decimal stays dark.
  always_comb begin
    seg = SEG_BLANK;
    if (!blank) begin
      case (value)
        4'd0:    seg = SEG_0;
        4'd1:    seg = SEG_1;
        4'd2:    seg = SEG_2;
        4'd3:    seg = SEG_3;
        4'd4:    seg = SEG_4;
        4'd5:    seg = SEG_5;
        4'd6:    seg = SEG_6;
        4'd7:    seg = SEG_7;
        4'd8:    seg = SEG_8;
        4'd9:    seg = SEG_9;
        default: seg = SEG_BLANK;
      endcase
    end
  end

endmodule

// File: rtl/display_mux.sv
// Display stream consumer: tracks the calculator's pos/dig writes in a
// digit buffer and scans it right-justified onto an N_DIG-digit
// common-anode 7-segment display, with busy (dp) and error overlays.
// Optional feature macro: DISP_ERRO_MSG_EN -- when defined the error state
// spells "Erro" on the four rightmost digits; otherwise the error state
// blanks all segments and lights every decimal point.
module display_mux
  import calc_pkg::*;
#(
  parameter int N_DIG    = 8,
  parameter int SCAN_DIV = 100000
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [1:0]       status,
  input  logic [3:0]       pos,
  input  logic [3:0]       dig,
  output logic [N_DIG-1:0] an,
  output logic [6:0]       seg,
  output logic             dp
);

  localparam int KW = (N_DIG > 1) ? $clog2(N_DIG) : 1;
  localparam int PW = $clog2(SCAN_DIV);
  localparam logic [3:0]    N_DIG_4  = 4'(N_DIG);
  localparam logic [KW-1:0] K_LAST   = KW'(N_DIG - 1);
  localparam logic [PW-1:0] PRE_LAST = PW'(SCAN_DIV - 1);

  logic [3:0]       pos_q;
  logic [3:0]       dig_q;
  logic [3:0]       digit_buf [N_DIG];
  logic [3:0]       count;
  logic [PW-1:0]    pre;
  logic [KW-1:0]    k;
  logic             wr_evt;
  logic [3:0]       k_ext;
  logic             in_num;
  logic [3:0]       rd_idx;
  logic [3:0]       rd_val;
  logic [6:0]       num_seg;
  logic [N_DIG-1:0] an_d;
  logic [6:0]       seg_d;
  logic             dp_d;

  // ---- stage 0: input capture and write detection ----
  assign wr_evt = (pos != pos_q) || (dig != dig_q);

  // Remember the last pos/dig pair so only changes count as writes.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pos_q <= POS_EMPTY;
      dig_q <= 4'd0;
    end else begin
      pos_q <= pos;
      dig_q <= dig;
    end
  end

  // Apply write events: store a digit and set the length, or clear the length.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < N_DIG; i++) digit_buf[i] <= 4'd0;
      count <= 4'd0;
    end else if (wr_evt) begin
      if (pos < N_DIG_4) begin
        digit_buf[pos[KW-1:0]] <= dig;
        count                  <= pos + 4'd1;
      end else if (pos == POS_EMPTY) begin
        count <= 4'd0;
      end
    end
  end

  // Prescaler holds each digit for SCAN_DIV cycles, then steps the scan index.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pre <= '0;
      k   <= '0;
    end else if (pre == PRE_LAST) begin
      pre <= '0;
      k   <= (k == K_LAST) ? '0 : k + KW'(1);
    end else begin
      pre <= pre + PW'(1);
    end
  end

  // ---- stage 1: right-justified render of the selected digit ----
  assign k_ext  = 4'(k);
  assign in_num = k_ext < count;
  assign rd_idx = count - 4'd1 - k_ext;
  assign rd_val = digit_buf[rd_idx[KW-1:0]];

  seg7_decoder u_dec (
    .value (rd_val),
    .blank (!in_num),
    .seg   (num_seg)
  );

  // Choose the glyph and decimal point for the current scan index and status.
  always_comb begin
    an_d  = ~(N_DIG'(1) << k);
    seg_d = num_seg;
    dp_d  = 1'b1;
    case (status)
      ST_ERRO: begin
`ifdef DISP_ERRO_MSG_EN
        case (k_ext)
          4'd3:    seg_d = SEG_E;
          4'd2:    seg_d = SEG_R;
          4'd1:    seg_d = SEG_R;
          4'd0:    seg_d = SEG_O;
          default: seg_d = SEG_BLANK;
        endcase
        dp_d = 1'b1;
`else
        seg_d = SEG_BLANK;
        dp_d  = 1'b0;
`endif
      end
      ST_OCUPADA: dp_d = (k != K_LAST);
      default:    dp_d = 1'b1;
    endcase
  end

  // Register the pin drivers; reset forces the display dark at once.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      an  <= '1;
      seg <= SEG_BLANK;
      dp  <= 1'b1;
    end else begin
      an  <= an_d;
      seg <= seg_d;
      dp  <= dp_d;
    end
  end

endmodule
